// File: rtl/clk_div_pkg.sv
// Shared definitions for the multi-channel clock divider: channel state
// encoding, default counter width and the LOAD_CH width helper.
package clk_div_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } ch_state_e;

   localparam int unsigned CNT_W_DEF = 32;

   // Channel-select width: clog2 of the channel count, never narrower than 1.
   function automatic int unsigned ch_sel_w(input int unsigned n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/clk_div_channel.sv
// One divider channel: IDLE/RUN/DRAIN FSM, half-period counter, shadow and
// active divisor registers, registered divided clock and rising-edge tick.
// Optional phase-align input sync_i exists only when CLK_DIV_MULTI_SYNC_EN
// is defined.
//
//  state    | meaning
//  ---------+-----------------------------------------------------------
//  ST_IDLE  | stopped, counter held at 0, clk_o low
//  ST_RUN   | counting, clk_o toggles every active+1 cycles
//  ST_DRAIN | enable dropped while clk_o high; finish the high phase
module clk_div_channel
   import clk_div_pkg::*;
#(
   parameter int unsigned CNT_W       = CNT_W_DEF,
   parameter int unsigned DEFAULT_DIV = 50_000_000
) (
   input  logic             CLK_IN,
   input  logic             RST,
   input  logic             en_i,
   input  logic             load_i,
   input  logic [CNT_W-1:0] div_i,
`ifdef CLK_DIV_MULTI_SYNC_EN
   input  logic             sync_i,
`endif
   output logic             clk_o,
   output logic             tick_o,
   output logic             running_o
);

   localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DEFAULT_DIV);

   ch_state_e        state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic [CNT_W-1:0] shadow_q;
   logic [CNT_W-1:0] active_q;
   logic             clk_q;
   logic             tick_q;
   logic             sync_w;

`ifdef CLK_DIV_MULTI_SYNC_EN
   assign sync_w = sync_i;
`else
   assign sync_w = 1'b0;
`endif

   assign cnt_d = cnt_q + CNT_W'(1);

   // Shadow divisor: written by a load strobe, sampled into active at toggles.
   always_ff @(posedge CLK_IN or posedge RST) begin
      if (RST) begin
         shadow_q <= DIV_RST;
      end else if (load_i) begin
         shadow_q <= div_i;
      end
   end

   // Channel FSM with counter, active divisor and registered outputs.
   always_ff @(posedge CLK_IN or posedge RST) begin
      if (RST) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         active_q <= DIV_RST;
         clk_q    <= 1'b0;
         tick_q   <= 1'b0;
      end else begin
         tick_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               cnt_q <= '0;
               clk_q <= 1'b0;
               if (en_i) begin
                  state_q  <= ST_RUN;
                  active_q <= shadow_q;
               end
            end
            ST_RUN, ST_DRAIN: begin
               if (sync_w) begin
                  // Phase align: restart the low half with the latest divisor.
                  cnt_q    <= '0;
                  clk_q    <= 1'b0;
                  active_q <= shadow_q;
               end else if (!en_i && !clk_q) begin
                  // Output already low, so stopping cannot leave a runt pulse.
                  state_q <= ST_IDLE;
                  cnt_q   <= '0;
               end else if (cnt_q == active_q) begin
                  cnt_q    <= '0;
                  clk_q    <= !clk_q;
                  active_q <= shadow_q;
                  tick_q   <= !clk_q;
                  // A falling toggle without enable completes the drain.
                  state_q  <= en_i ? ST_RUN : ST_IDLE;
               end else begin
                  cnt_q   <= cnt_d;
                  state_q <= en_i ? ST_RUN : ST_DRAIN;
               end
            end
            default: begin
               state_q <= ST_IDLE;
               cnt_q   <= '0;
               clk_q   <= 1'b0;
            end
         endcase
      end
   end

   assign clk_o     = clk_q;
   assign tick_o    = tick_q;
   assign running_o = (state_q != ST_IDLE);

endmodule

// File: rtl/clk_div_multi.sv
// Multi-channel runtime-programmable clock divider. Each channel produces a
// 50% duty divided clock and a one-cycle tick on its rising edge; divisor
// changes land only on half-period boundaries. Optional SYNC input, enabled
// by defining CLK_DIV_MULTI_SYNC_EN, phase-aligns all running channels.
module clk_div_multi
   import clk_div_pkg::*;
#(
   parameter int unsigned NUM_CH      = 2,
   parameter int unsigned CNT_W       = CNT_W_DEF,
   parameter int unsigned DEFAULT_DIV = 50_000_000
) (
   input  logic                          CLK_IN,
   input  logic                          RST,
   input  logic [NUM_CH-1:0]             EN,
   input  logic                          LOAD,
   input  logic [ch_sel_w(NUM_CH)-1:0]   LOAD_CH,
   input  logic [CNT_W-1:0]              DIV_IN,
`ifdef CLK_DIV_MULTI_SYNC_EN
   input  logic                          SYNC,
`endif
   output logic [NUM_CH-1:0]             CLK_OUT,
   output logic [NUM_CH-1:0]             TICK,
   output logic [NUM_CH-1:0]             RUNNING
);

   localparam int unsigned CH_W = ch_sel_w(NUM_CH);

   logic [NUM_CH-1:0] load_vec;

   // Channel indices beyond NUM_CH-1 match no strobe, so such loads are dropped.
   always_comb begin
      load_vec = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         load_vec[i] = LOAD && (LOAD_CH == CH_W'(i));
      end
   end

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      clk_div_channel #(
         .CNT_W       (CNT_W),
         .DEFAULT_DIV (DEFAULT_DIV)
      ) u_ch (
         .CLK_IN    (CLK_IN),
         .RST       (RST),
         .en_i      (EN[g]),
         .load_i    (load_vec[g]),
         .div_i     (DIV_IN),
`ifdef CLK_DIV_MULTI_SYNC_EN
         .sync_i    (SYNC),
`endif
         .clk_o     (CLK_OUT[g]),
         .tick_o    (TICK[g]),
         .running_o (RUNNING[g])
      );
   end

endmodule

// File: tb/tb_clk_div_multi.sv
// Directed bench for clk_div_multi with DEFAULT_DIV=3, NUM_CH=2.
module tb_clk_div_multi;

   logic        CLK_IN;
   logic        RST;
   logic [1:0]  EN;
   logic        LOAD;
   logic [0:0]  LOAD_CH;
   logic [31:0] DIV_IN;
`ifdef CLK_DIV_MULTI_SYNC_EN
   logic        SYNC;
`endif
   logic [1:0]  CLK_OUT;
   logic [1:0]  TICK;
   logic [1:0]  RUNNING;

   int total = 0;
   int bad   = 0;

   clk_div_multi #(
      .NUM_CH      (2),
      .CNT_W       (32),
      .DEFAULT_DIV (3)
   ) dut (
      .CLK_IN  (CLK_IN),
      .RST     (RST),
      .EN      (EN),
      .LOAD    (LOAD),
      .LOAD_CH (LOAD_CH),
      .DIV_IN  (DIV_IN),
`ifdef CLK_DIV_MULTI_SYNC_EN
      .SYNC    (SYNC),
`endif
      .CLK_OUT (CLK_OUT),
      .TICK    (TICK),
      .RUNNING (RUNNING)
   );

   initial CLK_IN = 1'b0;
   always #5 CLK_IN = ~CLK_IN;

   task automatic step();
      @(posedge CLK_IN);
      #1;
   endtask

   task automatic wait_tick(input int ch, input int maxc, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < maxc; i++) begin
         step();
         if (TICK[ch]) begin
            ok = 1'b1;
            break;
         end
      end
      total++;
      if (!ok) begin
         bad++;
         $display("FAIL wait_tick ch=%0d: no tick within %0d cycles", ch, maxc);
      end
   endtask

   task automatic test_reset();
      logic [5:0] got;
      #2;
      got = {CLK_OUT, TICK, RUNNING};
      total++;
      if (got !== 6'b0) begin
         bad++;
         $display("FAIL reset_hold: got %b want 000000", got);
      end
      step();
      RST = 1'b0;
      step();
      got = {CLK_OUT, TICK, RUNNING};
      total++;
      if (got !== 6'b0) begin
         bad++;
         $display("FAIL reset_release: got %b want 000000", got);
      end
   endtask

   // Channel 0 alone at div=3: rise 4 cycles after RUN entry, period 8.
   task automatic test_basic();
      logic [5:0] got, exp;
      logic       ec, et;
      EN = 2'b01;
      for (int n = 1; n <= 24; n++) begin
         step();
         ec  = (n >= 5) && ((((n - 5) / 4) % 2) == 0);
         et  = (n >= 5) && (((n - 5) % 8) == 0);
         exp = {1'b0, ec, 1'b0, et, 2'b01};
         got = {CLK_OUT, TICK, RUNNING};
         total++;
         if (got !== exp) begin
            bad++;
            $display("FAIL basic n=%0d: got %b want %b", n, got, exp);
         end
      end
   endtask

   // Load div=1 one cycle into a high phase: high stays 4, then 2-cycle halves.
   task automatic test_load();
      bit         ok;
      logic [1:0] got, exp;
      logic       ec, et;
      wait_tick(0, 20, ok);
      for (int k = 1; k <= 12; k++) begin
         step();
         if (k == 1) begin
            LOAD = 1'b1; LOAD_CH = 1'b0; DIV_IN = 32'd1;
         end else begin
            LOAD = 1'b0;
         end
         ec  = (k <= 3) || ((k >= 6) && ((((k - 4) / 2) % 2) == 1));
         et  = (k >= 6) && (((k - 6) % 4) == 0);
         exp = {ec, et};
         got = {CLK_OUT[0], TICK[0]};
         total++;
         if (got !== exp) begin
            bad++;
            $display("FAIL load k=%0d: got %b want %b", k, got, exp);
         end
      end
   endtask

   // Drop EN[0] one cycle after a rise at div=3: high phase completes, then idle.
   task automatic test_drain();
      bit         ok;
      logic [1:0] got, exp;
      step();
      LOAD = 1'b1; LOAD_CH = 1'b0; DIV_IN = 32'd3;
      step();
      LOAD = 1'b0;
      wait_tick(0, 20, ok);
      wait_tick(0, 20, ok);
      step();
      EN = 2'b00;
      for (int k = 2; k <= 7; k++) begin
         step();
         exp = (k <= 3) ? 2'b11 : 2'b00;
         got = {CLK_OUT[0], RUNNING[0]};
         total++;
         if (got !== exp) begin
            bad++;
            $display("FAIL drain k=%0d: got %b want %b", k, got, exp);
         end
      end
   endtask

   // div=0 on channel 1: toggles every cycle; channel 0 stays idle.
   task automatic test_div0();
      logic [5:0] got, exp;
      logic       ec;
      LOAD = 1'b1; LOAD_CH = 1'b1; DIV_IN = 32'd0;
      step();
      LOAD = 1'b0;
      EN   = 2'b10;
      step();
      got = {CLK_OUT, TICK, RUNNING};
      total++;
      if (got !== 6'b000010) begin
         bad++;
         $display("FAIL div0_entry: got %b want 000010", got);
      end
      for (int k = 1; k <= 8; k++) begin
         step();
         ec  = (k % 2) == 1;
         exp = {ec, 1'b0, ec, 1'b0, 2'b10};
         got = {CLK_OUT, TICK, RUNNING};
         total++;
         if (got !== exp) begin
            bad++;
            $display("FAIL div0 k=%0d: got %b want %b", k, got, exp);
         end
      end
   endtask

   // Async reset with CLK_OUT[0] high; afterwards both divisors back to 3.
   task automatic test_reset_mid();
      bit         ok;
      logic [5:0] got;
      logic [1:0] exp2;
      EN = 2'b11;
      wait_tick(0, 20, ok);
      step();
      RST = 1'b1;
      #1;
      got = {CLK_OUT, TICK, RUNNING};
      total++;
      if (got !== 6'b0) begin
         bad++;
         $display("FAIL reset_async: got %b want 000000", got);
      end
      EN = 2'b00;
      step();
      RST = 1'b0;
      step();
      EN = 2'b11;
      step();
      for (int k = 1; k <= 8; k++) begin
         step();
         exp2 = ((k >= 4) && (k <= 7)) ? 2'b11 : 2'b00;
         total++;
         if (CLK_OUT !== exp2) begin
            bad++;
            $display("FAIL reset_defaults k=%0d: got %b want %b", k, CLK_OUT, exp2);
         end
      end
      EN = 2'b00;
      for (int i = 0; i < 10; i++) step();
      total++;
      if (RUNNING !== 2'b00) begin
         bad++;
         $display("FAIL stop_all: got %b want 00", RUNNING);
      end
   endtask

`ifdef CLK_DIV_MULTI_SYNC_EN
   // Channels at div=3 and div=1 out of phase; SYNC with both shadows at 3.
   task automatic test_sync();
      logic [3:0] got, exp;
      logic       ec, et;
      LOAD = 1'b1; LOAD_CH = 1'b1; DIV_IN = 32'd1;
      step();
      LOAD = 1'b0;
      EN   = 2'b01;
      step();
      step();
      EN = 2'b11;
      for (int i = 0; i < 5; i++) step();
      LOAD = 1'b1; LOAD_CH = 1'b1; DIV_IN = 32'd3;
      step();
      LOAD = 1'b0;
      SYNC = 1'b1;
      step();
      SYNC = 1'b0;
      total++;
      if (CLK_OUT !== 2'b00) begin
         bad++;
         $display("FAIL sync_zero: got %b want 00", CLK_OUT);
      end
      for (int k = 1; k <= 16; k++) begin
         step();
         ec  = ((k >= 4) && (k <= 7)) || ((k >= 12) && (k <= 15));
         et  = (k == 4) || (k == 12);
         exp = {ec, ec, et, et};
         got = {CLK_OUT, TICK};
         total++;
         if (got !== exp) begin
            bad++;
            $display("FAIL sync k=%0d: got %b want %b", k, got, exp);
         end
      end
   endtask
`endif

   initial begin
      RST     = 1'b1;
      EN      = 2'b00;
      LOAD    = 1'b0;
      LOAD_CH = 1'b0;
      DIV_IN  = 32'd0;
`ifdef CLK_DIV_MULTI_SYNC_EN
      SYNC    = 1'b0;
`endif
      test_reset();
      test_basic();
      test_load();
      test_drain();
      test_div0();
      test_reset_mid();
`ifdef CLK_DIV_MULTI_SYNC_EN
      test_sync();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
